// File: rtl/seq_mpy.sv
// seq_mpy: sequential radix-4 multiplier, two multiplier bits per cycle,
// signed (sign/magnitude) or unsigned operands.
//
// Ports:
//   i_clk     clock, all state updates on the rising edge
//   i_reset   synchronous, active-high reset
//   i_stb     start request, accepted only while o_busy is low
//   i_signed  1 = two's-complement operands, 0 = unsigned
//   i_a       multiplier (NA bits), sampled at accept
//   i_b       multiplicand (NB bits), sampled at accept
//   o_busy    operation in progress
//   o_done    one-cycle pulse, o_p holds a new product
//   o_p       product (NA+NB bits), held until the next o_done
module seq_mpy #(
   parameter int NA = 16,
   parameter int NB = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_stb,
   input  logic             i_signed,
   input  logic [NA-1:0]    i_a,
   input  logic [NB-1:0]    i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [NA+NB-1:0] o_p
);

   localparam int PW    = NA + NB;
   localparam int STEPS = NA / 2;
   localparam int CW    = $clog2(STEPS + 1);

   localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);
   localparam logic [CW-1:0] ONE_C = CW'(1);
   localparam logic [NA-1:0] ONE_A = NA'(1);
   localparam logic [NB-1:0] ONE_B = NB'(1);
   localparam logic [PW-1:0] ONE_P = PW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [NA-1:0] a_q;
   logic [NB-1:0] b_q;
   logic          neg_q;
   logic [PW-1:0] acc_q;
   logic [CW-1:0] cnt_q;
   logic          done_q;
   logic [PW-1:0] p_q;

   logic          accept;
   logic          a_neg;
   logic          b_neg;
   logic [NA-1:0] a_mag;
   logic [NB-1:0] b_mag;
   logic [NB+1:0] pp;
   logic [PW-1:0] pp_ext;
   logic [CW:0]   shamt;
   logic [PW-1:0] acc_nxt;
   logic [PW-1:0] p_nxt;

   assign accept = (state_q == IDLE) && i_stb;

   // The most negative value negates to itself, which read as
   // unsigned is exactly its magnitude 2^(N-1).
   assign a_neg = i_signed & i_a[NA-1];
   assign b_neg = i_signed & i_b[NB-1];
   assign a_mag = a_neg ? (~i_a + ONE_A) : i_a;
   assign b_mag = b_neg ? (~i_b + ONE_B) : i_b;

   // Partial product of one radix-4 digit: 0, B, 2B or 3B,
   // kept in NB+2 bits so 3B never truncates.
   always_comb begin
      pp = '0;
      if (a_q[0])
         pp = pp + {2'b00, b_q};
      if (a_q[1])
         pp = pp + {1'b0, b_q, 1'b0};
   end

   always_comb begin
      pp_ext = '0;
      pp_ext[NB+1:0] = pp;
   end

   // Digit k lands at bit 2k of the accumulator.
   assign shamt   = {cnt_q, 1'b0};
   assign acc_nxt = acc_q + (pp_ext << shamt);
   assign p_nxt   = neg_q ? (~acc_q + ONE_P) : acc_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (i_stb) state_d = RUN;
         RUN:  if (cnt_q == LAST) state_d = FIX;
         FIX:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q   <= a_mag;
                  b_q   <= b_mag;
                  neg_q <= a_neg ^ b_neg;
                  acc_q <= '0;
                  cnt_q <= '0;
               end
            end
            RUN: begin
               acc_q <= acc_nxt;
               a_q   <= a_q >> 2;
               cnt_q <= cnt_q + ONE_C;
            end
            FIX: begin
               p_q    <= p_nxt;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_busy = (state_q != IDLE);
   assign o_done = done_q;
   assign o_p    = p_q;

endmodule

// File: tb/tb_seq_mpy.sv
// tb_seq_mpy: directed self-checking bench for seq_mpy, NA=NB=8.
// Edge counts include the acceptance edge as edge 1.
module tb_seq_mpy;

   logic        clk;
   logic        rst;
   logic        stb;
   logic        sgn;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] p;

   int checks;
   int failures;
   int edges;
   int busy_cnt;
   int gap;
   int extra_done;
   int busy_seen;

   seq_mpy #(.NA(8), .NB(8)) dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_stb    (stb),
      .i_signed (sgn),
      .i_a      (a),
      .i_b      (b),
      .o_busy   (busy),
      .o_done   (done),
      .o_p      (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present operands, take the acceptance edge, drop i_stb.
   task automatic accept_op(input logic [7:0] va,
                            input logic [7:0] vb,
                            input logic vs);
      @(negedge clk);
      a = va; b = vb; sgn = vs; stb = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0;
      edges = 1;
      busy_cnt = busy ? 1 : 0;
   endtask

   task automatic wait_done();
      while (!done && edges < 20) begin
         @(posedge clk); #1;
         edges++;
         if (busy) busy_cnt++;
      end
   endtask

   task automatic run_op(input string tag,
                         input logic [7:0] va,
                         input logic [7:0] vb,
                         input logic vs,
                         input logic [15:0] exp);
      accept_op(va, vb, vs);
      wait_done();
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_p"}, {16'd0, p}, {16'd0, exp});
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; stb = 1'b0; sgn = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_p", {16'd0, p}, 32'd0);
      rst = 1'b0;

      // 255*255 unsigned, with latency and busy length
      accept_op(8'hFF, 8'hFF, 1'b0);
      wait_done();
      chk("u_ff_p", {16'd0, p}, 32'h0000FE01);
      chk("u_ff_edges", edges, 32'd6);
      chk("u_ff_busy", busy_cnt, 32'd5);
      chk("u_ff_excl", {31'd0, busy & done}, 32'd0);
      @(posedge clk); #1;
      chk("u_ff_pulse", {31'd0, done}, 32'd0);
      chk("u_ff_hold", {16'd0, p}, 32'h0000FE01);

      run_op("s_m3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1);
      run_op("s_80x80",  8'h80, 8'h80, 1'b1, 16'h4000);
      run_op("u_80x80",  8'h80, 8'h80, 1'b0, 16'h4000);
      run_op("s_ffx01",  8'hFF, 8'h01, 1'b1, 16'hFFFF);
      run_op("u_ffx01",  8'hFF, 8'h01, 1'b0, 16'h00FF);
      run_op("s_7fx80",  8'h7F, 8'h80, 1'b1, 16'hC080);
      run_op("s_m1xm1",  8'hFF, 8'hFF, 1'b1, 16'h0001);

      // busy-ignore: second request during RUN must not start
      accept_op(8'd7, 8'd9, 1'b0);
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      a = 8'h33; b = 8'h44; stb = 1'b1;
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      stb = 1'b0;
      wait_done();
      chk("ign_p", {16'd0, p}, 32'h0000003F);
      chk("ign_edges", edges, 32'd6);
      extra_done = 0;
      busy_seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) extra_done++;
         if (busy) busy_seen++;
      end
      chk("ign_no_done", extra_done, 32'd0);
      chk("ign_no_start", busy_seen, 32'd0);
      chk("ign_hold", {16'd0, p}, 32'h0000003F);

      // back-to-back with i_stb held high
      @(negedge clk);
      a = 8'd3; b = 8'd4; sgn = 1'b0; stb = 1'b1;
      @(posedge clk); #1;
      a = 8'd5; b = 8'd6;
      edges = 1;
      busy_cnt = 1;
      wait_done();
      chk("b2b_p1", {16'd0, p}, 32'h0000000C);
      gap = 0;
      do begin
         @(posedge clk); #1;
         gap++;
         if (gap == 1) stb = 1'b0;
      end while (!done && gap < 20);
      chk("b2b_gap", gap, 32'd6);
      chk("b2b_p2", {16'd0, p}, 32'h0000001E);

      // reset during RUN aborts the operation
      accept_op(8'hFF, 8'hFF, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_p", {16'd0, p}, 32'd0);
      extra_done = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) extra_done++;
      end
      chk("abort_no_done", extra_done, 32'd0);
      accept_op(8'd2, 8'd2, 1'b0);
      wait_done();
      chk("post_p", {16'd0, p}, 32'h00000004);
      chk("post_edges", edges, 32'd6);

      // reset wins over a simultaneous start
      @(negedge clk);
      a = 8'd9; b = 8'd9; stb = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0; rst = 1'b0;
      chk("rst_vs_stb", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
